// File: rtl/shift_unit_pkg.sv
// Shared definitions for the multi-cycle MIPS shift unit: op encodings,
// FSM states and default widths.
package mips_shift_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SHW_DEF   = 5;

    localparam logic [2:0] SH_NOP  = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_SLL  = 3'b010;
    localparam logic [2:0] SH_SRL  = 3'b011;
    localparam logic [2:0] SH_SRA  = 3'b100;
    localparam logic [2:0] SH_ROR  = 3'b101;
    localparam logic [2:0] SH_ROL  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Ops that go through the counted SHIFT phase (SLL..ROL).
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op >= SH_SLL) && (op <= SH_ROL);
    endfunction

endpackage

// File: rtl/shift_unit_if.sv
// Request/response bundle between the control unit and the shift unit.
interface shift_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] entry_data;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, entry_data, shamt,
        input  busy, done, result
    );

    modport slave (
        input  start, op, entry_data, shamt,
        output busy, done, result
    );
endinterface

// File: rtl/shift_unit_step.sv
// Combinational one-bit step of a shift/rotate; the unit's only datapath logic.
module shift_step
    import mips_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (op_i)
            SH_SLL:  data_o = {data_i[WIDTH-2:0], 1'b0};
            SH_SRL:  data_o = {1'b0, data_i[WIDTH-1:1]};
            SH_SRA:  data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
            SH_ROR:  data_o = {data_i[0], data_i[WIDTH-1:1]};
            SH_ROL:  data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Sequential shifter: latches operand/amount on start, shifts one bit per
// clock, pulses done for one cycle and holds the result for write-back.
module shift_unit
    import mips_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    shift_unit_if.slave bus
);

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [SHW-1:0]   cnt_q;
    logic [2:0]       op_q;
    logic             busy_q;
    logic             done_q;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data_i (data_q),
        .op_i   (op_q),
        .data_o (data_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            op_q    <= SH_NOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        if (is_shift_op(bus.op)) begin
                            data_q <= bus.entry_data;
                            cnt_q  <= bus.shamt;
                            op_q   <= bus.op;
                            if (bus.shamt != '0) begin
                                state_q <= ST_SHIFT;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            // LOAD overwrites the register; NOP and 3'b111 leave it.
                            if (bus.op == SH_LOAD) begin
                                data_q <= bus.entry_data;
                            end
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = data_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: one task per scenario, inline comparisons.
module tb_shift_unit;
    import mips_shift_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    shift_unit_if #(.WIDTH(32), .SHW(5)) bus ();

    shift_unit #(.WIDTH(32), .SHW(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    int busy_cnt, done_cyc, done_cnt, overlap;

    // Issue one start and observe sh+4 cycles after acceptance (cycle 1 = first
    // cycle after the accepting edge). Optionally re-assert start while busy/done.
    task automatic run_op(input logic [2:0] op, input logic [31:0] data,
                          input logic [4:0] sh, input bit inject);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.entry_data = data;
        bus.shamt = sh;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        busy_cnt = 0;
        done_cyc = 0;
        done_cnt = 0;
        overlap = 0;
        for (int c = 1; c <= int'(sh) + 4; c++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (bus.busy && bus.done) overlap++;
            if (inject && (bus.busy || bus.done)) begin
                bus.start = 1'b1;
                bus.op = SH_LOAD;
                bus.entry_data = 32'h1234_5678;
                bus.shamt = 5'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 00000000",
                     bus.busy, bus.done, bus.result);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        $display("reset: busy=%b done=%b result=%h", bus.busy, bus.done, bus.result);
    endtask

    task automatic test_sll();
        run_op(SH_SLL, 32'h0000_0001, 5'd4, 1'b0);
        $display("SLL 00000001 by 4: result=%h busy_cycles=%0d done_cycle=%0d",
                 bus.result, busy_cnt, done_cyc);
        checks++;
        if (busy_cnt !== 4) begin
            errors++; $display("FAIL sll_busy: got %0d cycles, required 4", busy_cnt);
        end
        checks++;
        if (done_cyc !== 5 || done_cnt !== 1) begin
            errors++; $display("FAIL sll_done: cycle %0d count %0d, required cycle 5 count 1", done_cyc, done_cnt);
        end
        checks++;
        if (bus.result !== 32'h0000_0010) begin
            errors++; $display("FAIL sll_result: got %h, required 00000010", bus.result);
        end
        checks++;
        if (overlap !== 0) begin
            errors++; $display("FAIL sll_exclusive: busy&done in %0d cycles, required 0", overlap);
        end
    endtask

    task automatic test_sra_srl();
        run_op(SH_SRA, 32'h8000_0000, 5'd31, 1'b0);
        $display("SRA 80000000 by 31: result=%h done_cycle=%0d", bus.result, done_cyc);
        checks++;
        if (bus.result !== 32'hFFFF_FFFF || done_cyc !== 32) begin
            errors++; $display("FAIL sra_31: got %h at cycle %0d, required ffffffff at cycle 32", bus.result, done_cyc);
        end
        run_op(SH_SRL, 32'h8000_0000, 5'd31, 1'b0);
        $display("SRL 80000000 by 31: result=%h busy_cycles=%0d", bus.result, busy_cnt);
        checks++;
        if (bus.result !== 32'h0000_0001 || busy_cnt !== 31) begin
            errors++; $display("FAIL srl_31: got %h busy %0d, required 00000001 busy 31", bus.result, busy_cnt);
        end
    endtask

    task automatic test_rotate_zero();
        run_op(SH_ROR, 32'h0000_0001, 5'd1, 1'b0);
        $display("ROR 00000001 by 1: result=%h", bus.result);
        checks++;
        if (bus.result !== 32'h8000_0000) begin
            errors++; $display("FAIL ror_1: got %h, required 80000000", bus.result);
        end
        run_op(SH_ROL, 32'h8000_0001, 5'd4, 1'b0);
        $display("ROL 80000001 by 4: result=%h", bus.result);
        checks++;
        if (bus.result !== 32'h0000_0018) begin
            errors++; $display("FAIL rol_4: got %h, required 00000018", bus.result);
        end
        run_op(SH_SLL, 32'hA5A5_0F0F, 5'd0, 1'b0);
        $display("SLL a5a50f0f by 0: result=%h busy_cycles=%0d done_cycle=%0d",
                 bus.result, busy_cnt, done_cyc);
        checks++;
        if (bus.result !== 32'hA5A5_0F0F || busy_cnt !== 0 || done_cyc !== 1) begin
            errors++; $display("FAIL sll_zero: got %h busy %0d done %0d, required a5a50f0f busy 0 done 1",
                               bus.result, busy_cnt, done_cyc);
        end
    endtask

    task automatic test_load_nop();
        run_op(SH_LOAD, 32'hDEAD_BEEF, 5'd9, 1'b0);
        $display("LOAD deadbeef: result=%h busy_cycles=%0d done_cycle=%0d", bus.result, busy_cnt, done_cyc);
        checks++;
        if (bus.result !== 32'hDEAD_BEEF || busy_cnt !== 0 || done_cyc !== 1) begin
            errors++; $display("FAIL load: got %h busy %0d done %0d, required deadbeef busy 0 done 1",
                               bus.result, busy_cnt, done_cyc);
        end
        run_op(SH_NOP, 32'h0101_0101, 5'd2, 1'b0);
        $display("NOP: result=%h done_cycle=%0d", bus.result, done_cyc);
        checks++;
        if (bus.result !== 32'hDEAD_BEEF || done_cyc !== 1 || done_cnt !== 1) begin
            errors++; $display("FAIL nop: got %h done %0d x%0d, required deadbeef done 1 x1",
                               bus.result, done_cyc, done_cnt);
        end
        run_op(3'b111, 32'h0202_0202, 5'd5, 1'b0);
        $display("OP111: result=%h done_cycle=%0d", bus.result, done_cyc);
        checks++;
        if (bus.result !== 32'hDEAD_BEEF || done_cyc !== 1 || busy_cnt !== 0) begin
            errors++; $display("FAIL op111: got %h done %0d busy %0d, required deadbeef done 1 busy 0",
                               bus.result, done_cyc, busy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        run_op(SH_SRL, 32'hF000_0000, 5'd8, 1'b1);
        $display("SRL f0000000 by 8 with ignored starts: result=%h done_count=%0d", bus.result, done_cnt);
        checks++;
        if (bus.result !== 32'h00F0_0000) begin
            errors++; $display("FAIL ignore_start_result: got %h, required 00f00000", bus.result);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== 9 || busy_cnt !== 8) begin
            errors++; $display("FAIL ignore_start_done: count %0d cycle %0d busy %0d, required 1 9 8",
                               done_cnt, done_cyc, busy_cnt);
        end
    endtask

    task automatic test_reset_mid_op();
        int late_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = SH_SRL;
        bus.entry_data = 32'hF000_0000;
        bus.shamt = 5'd8;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        $display("reset mid-shift: busy=%b done=%b result=%h", bus.busy, bus.done, bus.result);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
            errors++; $display("FAIL mid_reset_state: busy=%b done=%b result=%h, required 0 0 00000000",
                               bus.busy, bus.done, bus.result);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        late_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.done || bus.busy) late_done++;
            @(negedge clk);
        end
        checks++;
        if (late_done !== 0) begin
            errors++; $display("FAIL mid_reset_no_done: activity in %0d cycles, required 0", late_done);
        end
        run_op(SH_SLL, 32'h0000_0001, 5'd2, 1'b0);
        $display("SLL 00000001 by 2 after reset: result=%h", bus.result);
        checks++;
        if (bus.result !== 32'h0000_0004 || done_cyc !== 3) begin
            errors++; $display("FAIL post_reset_sll: got %h done %0d, required 00000004 done 3",
                               bus.result, done_cyc);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op = SH_NOP;
        bus.entry_data = '0;
        bus.shamt = '0;
        test_reset();
        test_sll();
        test_sra_srl();
        test_rotate_zero();
        test_load_nop();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
